baud_gen_frac: RTL and testbench
================================

// Module: baud_gen_frac
// PURPOSE
//  Fractional-N baud tick generator for the UART TX/RX datapaths.
//  Produces an oversample tick (os_tick) at average period DIV_INT+1+DIV_FRAC/2^FRAC_W clk cycles,
//  plus bit-rate (bit_tick) and mid-bit (mid_tick) strobes derived from it.
//  Supports glitch-free runtime divisor reload, enable gating and phase resync for RX start-bit alignment.
// PARAMETERS
//  DIV_W     16    width of integer divisor
//  FRAC_W    4     width of fractional divisor / phase accumulator
//  OSR       16    oversample ticks per bit (>=2, power of 2 not required)
//  DEF_INT   325   integer divisor loaded at reset
//  DEF_FRAC  0     fractional divisor loaded at reset
// PORTS
//  clk       in   1                      system clock
//  reset_n   in   1                      async active-low reset
//  en        in   1                      1 = run; 0 = freeze all counters, ticks forced 0
//  sync_clr  in   1                      pulse: restart phase (counter, accumulator, os_idx to 0)
//  load      in   1                      pulse: capture div_int/div_frac into shadow regs
//  div_int   in   DIV_W                  new integer divisor (period-1)
//  div_frac  in   FRAC_W                 new fractional divisor
//  os_tick   out  1                      1-cycle oversample strobe
//  bit_tick  out  1                      1-cycle strobe on last os_tick of each bit
//  mid_tick  out  1                      1-cycle strobe on os_tick with os_idx == OSR/2-1
//  os_idx    out  $clog2(OSR)            current oversample index 0..OSR-1
// BEHAVIOUR
//  Reset (async, reset_n=0): cnt=0, frac_acc=0, carry=0, os_idx=0, shadow int/frac = DEF_INT/DEF_FRAC,
//    os_tick=bit_tick=mid_tick=0. All outputs registered; exit from reset is synchronous to clk.
//  Period counter: cnt counts 0..limit, limit = int_q + carry (DIV_W+1 bit compare, no overflow).
//    os_tick=1 in the cycle after cnt==limit is seen (registered); cnt returns to 0 same edge.
//  Fractional: on each os_tick event {carry, frac_acc} <= frac_acc + frac_q (FRAC_W+1 bit sum);
//    carry stretches the NEXT period by one cycle. First period after reset/sync_clr is int_q+1 cycles.
//  div_int==0, div_frac==0: os_tick every cycle (continuous high while en=1).
//  Reload: load captures div_int/div_frac into pending regs; pending -> int_q/frac_q on the next
//    os_tick event (period boundary), never mid-period. If en=0, pending applies immediately.
//    load and os_tick event in same cycle: new value used starting with the following period.
//    Multiple loads before a boundary: last one wins.
//  os_idx increments on each os_tick event, wraps OSR-1 -> 0; bit_tick asserted with the os_tick
//    whose event wraps os_idx; mid_tick with the os_tick where os_idx was OSR/2-1.
//  en=0: cnt, frac_acc, carry, os_idx hold; all ticks 0 next cycle; resume continues exact phase.
//  sync_clr (priority over en and load-apply): next edge cnt=0, frac_acc=0, carry=0, os_idx=0,
//    ticks 0 that cycle; a pending load is retained and applied at the next boundary.
//  Reset mid-operation: immediate return to reset state incl. shadow regs; pending load discarded.
// TESTING
//  1 reset, OSR=4, default regs overridden via load int=3 frac=0, en=1 -> os_tick every 4 clk, bit_tick
//    every 16 clk, mid_tick on 2nd os_tick of each bit; os_idx sequence 0,1,2,3,0.
//  2 int=3 frac=8 (FRAC_W=4) -> period sequence 4,4,5,4,5,...; 32 os_ticks span exactly 144 clk.
//  3 int=0 frac=0 -> os_tick high every cycle; bit_tick every OSR cycles; no X or stall.
//  4 load int=9 two cycles into a 4-cycle period -> current period still 4 clk, next period 10 clk.
//  5 en low for 7 cycles mid-period then high -> ticks 0 while low, phase resumes with remaining count;
//    sync_clr mid-bit -> no tick that cycle, next os_tick int_q+1 clk later, os_idx=1 after it.
//  6 assert reset_n=0 asynchronously mid-period -> outputs 0 without clk edge, shadow = DEF_INT/DEF_FRAC.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator: oversample tick with dual-modulus period,
// plus bit and mid-bit strobes, glitch-free divisor reload and phase resync.
module baud_gen_frac #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OSR      = 16,
  parameter int DEF_INT  = 325,
  parameter int DEF_FRAC = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    sync_clr,
  input  logic                    load,
  input  logic [DIV_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  output logic                    os_tick,
  output logic                    bit_tick,
  output logic                    mid_tick,
  output logic [$clog2(OSR)-1:0]  os_idx
);

  localparam int IDX_W = $clog2(OSR);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OSR - 1);
  localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OSR / 2 - 1);

  logic [DIV_W:0]    cnt;
  logic [FRAC_W-1:0] frac_acc;
  logic              carry;
  logic [DIV_W-1:0]  int_q;
  logic [FRAC_W-1:0] frac_q;
  logic [DIV_W-1:0]  pend_int;
  logic [FRAC_W-1:0] pend_frac;
  logic              pend_valid;

  logic [DIV_W:0]    limit;
  logic              tick_ev;
  logic              apply;
  logic [DIV_W-1:0]  new_int;
  logic [FRAC_W-1:0] new_frac;
  logic [FRAC_W:0]   frac_sum;

  // The carry from the previous period's accumulation stretches this one by a cycle.
  assign limit    = {1'b0, int_q} + {{DIV_W{1'b0}}, carry};
  assign tick_ev  = en && !sync_clr && (cnt == limit);
  assign frac_sum = {1'b0, frac_acc} + {1'b0, frac_q};

  // A divisor is only swapped at a period boundary, or at once while frozen.
  assign apply    = !sync_clr && (tick_ev || !en) && (load || pend_valid);
  assign new_int  = load ? div_int  : pend_int;
  assign new_frac = load ? div_frac : pend_frac;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      frac_acc <= '0;
      carry    <= 1'b0;
      os_idx   <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else begin
      os_tick  <= tick_ev;
      bit_tick <= tick_ev && (os_idx == IDX_LAST);
      mid_tick <= tick_ev && (os_idx == IDX_MID);
      if (sync_clr) begin
        cnt      <= '0;
        frac_acc <= '0;
        carry    <= 1'b0;
        os_idx   <= '0;
      end else if (en) begin
        if (tick_ev) begin
          cnt               <= '0;
          {carry, frac_acc} <= frac_sum;
          os_idx            <= (os_idx == IDX_LAST) ? '0 : os_idx + IDX_W'(1);
        end else begin
          cnt <= cnt + (DIV_W + 1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_q      <= DIV_W'(DEF_INT);
      frac_q     <= FRAC_W'(DEF_FRAC);
      pend_int   <= '0;
      pend_frac  <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (apply) begin
        int_q      <= new_int;
        frac_q     <= new_frac;
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_int   <= div_int;
        pend_frac  <= div_frac;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: tick-time arithmetic model compared every
// cycle, plus hand-computed period/index expectations for directed scenarios.
module tb_baud_gen_frac;

  localparam int DIV_W   = 16;
  localparam int FRAC_W  = 4;
  localparam int OSR     = 4;
  localparam int DEF_INT = 325;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              en = 1'b0;
  logic              sync_clr = 1'b0;
  logic              load = 1'b0;
  logic [DIV_W-1:0]  div_int = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              os_tick, bit_tick, mid_tick;
  logic [1:0]        os_idx;

  baud_gen_frac #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR), .DEF_INT(DEF_INT), .DEF_FRAC(0)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .sync_clr(sync_clr), .load(load),
    .div_int(div_int), .div_frac(div_frac),
    .os_tick(os_tick), .bit_tick(bit_tick), .mid_tick(mid_tick), .os_idx(os_idx)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tick_cyc[$];
  int tick_idx[$];
  int tick_bit[$];
  int tick_mid[$];

  // Model: the k-th tick of a divisor segment lands on run cycle
  // k*(I+1) + c0 + floor((a0 + (k-1)*F) / 2^FRAC_W).
  int m_i = DEF_INT, m_f = 0, m_a0 = 0, m_c0 = 0, m_k = 0, m_run = 0, m_total = 0;
  int m_pi = 0, m_pf = 0;
  bit m_pv = 1'b0;
  bit e_os = 1'b0, e_bit = 1'b0, e_mid = 1'b0;
  logic [1:0] e_idx = '0;

  function automatic int t_of(input int k);
    if (k == 0) return 0;
    return k * (m_i + 1) + m_c0 + ((m_a0 + (k - 1) * m_f) >> FRAC_W);
  endfunction

  initial forever begin
    bit tick;
    int tk, sum, prev;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_i = DEF_INT; m_f = 0; m_a0 = 0; m_c0 = 0; m_k = 0; m_run = 0; m_total = 0;
      m_pv = 1'b0; e_os = 1'b0; e_bit = 1'b0; e_mid = 1'b0; e_idx = '0;
    end else begin
      tick = 1'b0;
      if (load) begin m_pi = int'(div_int); m_pf = int'(div_frac); m_pv = 1'b1; end
      if (sync_clr) begin
        m_run = 0; m_k = 0; m_a0 = 0; m_c0 = 0; m_total = 0;
      end else begin
        if (en) begin
          m_run++;
          if (m_run == t_of(m_k + 1)) begin m_k++; m_total++; tick = 1'b1; end
        end
        if ((tick || !en) && m_pv) begin
          if (m_k > 0) begin
            tk   = t_of(m_k);
            sum  = m_a0 + m_k * m_f;
            prev = m_a0 + (m_k - 1) * m_f;
            m_c0 = (sum >> FRAC_W) - (prev >> FRAC_W);
            m_a0 = sum % (1 << FRAC_W);
            m_run = m_run - tk;
            m_k  = 0;
          end
          m_i = m_pi; m_f = m_pf; m_pv = 1'b0;
        end
      end
      e_os  = tick;
      e_idx = 2'(m_total % OSR);
      e_bit = tick && (m_total % OSR == 0);
      e_mid = tick && (m_total % OSR == OSR / 2);
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle comparison against the model, plus a log of every observed tick.
  initial forever begin
    @(negedge clk);
    n_assert++;
    if ({os_tick, bit_tick, mid_tick, os_idx} !== {e_os, e_bit, e_mid, e_idx}) begin
      n_fail++;
      $display("FAIL cycle %0d outputs: got os=%b bit=%b mid=%b idx=%0d, expected os=%b bit=%b mid=%b idx=%0d",
               cyc, os_tick, bit_tick, mid_tick, os_idx, e_os, e_bit, e_mid, e_idx);
    end
    if (os_tick === 1'b1) begin
      tick_cyc.push_back(cyc);
      tick_idx.push_back(int'(os_idx));
      tick_bit.push_back(int'(bit_tick));
      tick_mid.push_back(int'(mid_tick));
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_assert++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_ticks(input int n, input int budget);
    int target, w;
    target = tick_cyc.size() + n;
    w = 0;
    while (tick_cyc.size() < target && w < budget) begin @(posedge clk); #2; w++; end
    if (tick_cyc.size() < target) begin
      n_assert++; n_fail++;
      $display("FAIL wait_ticks timeout: got %0d ticks, expected %0d", tick_cyc.size(), target);
      finish_test();
    end
  endtask

  task automatic reload_frozen(input int di, input int df);
    en = 1'b0; div_int = DIV_W'(di); div_frac = FRAC_W'(df); load = 1'b1;
    cycles(1);
    load = 1'b0; sync_clr = 1'b1;
    cycles(1);
    sync_clr = 1'b0;
  endtask

  initial begin
    int base, p, b, nb;
    int exp_seq[4];
    exp_seq = '{1, 2, 3, 0};

    // Reset state
    cycles(3);
    check("reset os_tick", int'(os_tick), 0);
    check("reset bit_tick", int'(bit_tick), 0);
    check("reset mid_tick", int'(mid_tick), 0);
    check("reset os_idx", int'(os_idx), 0);
    reset_n = 1'b1;
    cycles(1);

    // 1: int=3 frac=0, OSR=4
    reload_frozen(3, 0);
    base = tick_cyc.size(); p = cyc; en = 1'b1;
    wait_ticks(8, 100);
    check("t1 first period", tick_cyc[base] - p, 4);
    check("t1 period", tick_cyc[base + 1] - tick_cyc[base], 4);
    for (int i = 0; i < 4; i++) check($sformatf("t1 os_idx[%0d]", i), tick_idx[base + i], exp_seq[i]);
    check("t1 mid on 2nd tick", tick_mid[base + 1], 1);
    check("t1 mid on 6th tick", tick_mid[base + 5], 1);
    check("t1 bit on 4th tick", tick_bit[base + 3], 1);
    check("t1 bit interval", tick_cyc[base + 7] - tick_cyc[base + 3], 16);

    // 2: int=3 frac=8 -> 4,4,5,4,5,...
    reload_frozen(3, 8);
    base = tick_cyc.size(); p = cyc; en = 1'b1;
    wait_ticks(33, 400);
    check("t2 first period", tick_cyc[base] - p, 4);
    check("t2 period 2", tick_cyc[base + 1] - tick_cyc[base], 4);
    check("t2 period 3", tick_cyc[base + 2] - tick_cyc[base + 1], 5);
    check("t2 period 4", tick_cyc[base + 3] - tick_cyc[base + 2], 4);
    check("t2 period 5", tick_cyc[base + 4] - tick_cyc[base + 3], 5);
    check("t2 32 periods span", tick_cyc[base + 32] - tick_cyc[base], 144);

    // 3: int=0 frac=0 -> continuous
    reload_frozen(0, 0);
    base = tick_cyc.size(); en = 1'b1;
    wait_ticks(20, 40);
    check("t3 20 ticks in 20 cycles", tick_cyc[base + 19] - tick_cyc[base], 19);
    nb = 0;
    for (int i = 0; i < 16; i++) nb += tick_bit[base + i];
    check("t3 bit_ticks per 16 cycles", nb, 4);

    // 4: load mid-period applies at the next boundary
    reload_frozen(3, 0);
    en = 1'b1;
    wait_ticks(1, 20);
    b = tick_cyc.size() - 1;
    div_int = 16'd9; load = 1'b1;
    cycles(1);
    load = 1'b0;
    wait_ticks(2, 40);
    check("t4 current period", tick_cyc[b + 1] - tick_cyc[b], 4);
    check("t4 next period", tick_cyc[b + 2] - tick_cyc[b + 1], 10);

    // 5: freeze for 7 cycles mid-period, then resync mid-bit
    wait_ticks(1, 20);
    b = tick_cyc.size() - 1;
    cycles(2);
    en = 1'b0;
    cycles(3);
    check("t5 os_tick while frozen", int'(os_tick), 0);
    cycles(4);
    en = 1'b1;
    wait_ticks(1, 40);
    check("t5 stretched period", tick_cyc[b + 1] - tick_cyc[b], 17);
    wait_ticks(1, 20);
    check("t5 period after resume", tick_cyc[b + 2] - tick_cyc[b + 1], 10);
    cycles(3);
    sync_clr = 1'b1;
    cycles(1);
    sync_clr = 1'b0;
    p = cyc;
    check("t5 os_idx after sync_clr", int'(os_idx), 0);
    check("t5 os_tick after sync_clr", int'(os_tick), 0);
    wait_ticks(1, 20);
    b = tick_cyc.size() - 1;
    check("t5 period after sync_clr", tick_cyc[b] - p, 10);
    check("t5 os_idx after first tick", tick_idx[b], 1);

    // 6: async reset mid-operation restores default divisor
    div_int = 16'd0; div_frac = 4'd0; load = 1'b1;
    cycles(1);
    load = 1'b0;
    wait_ticks(4, 40);
    check("t6 os_tick before reset", int'(os_tick), 1);
    #1 reset_n = 1'b0;
    #1;
    check("t6 async os_tick", int'(os_tick), 0);
    check("t6 async bit_tick", int'(bit_tick), 0);
    check("t6 async mid_tick", int'(mid_tick), 0);
    check("t6 async os_idx", int'(os_idx), 0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    p = cyc;
    wait_ticks(1, 400);
    check("t6 default period", tick_cyc[tick_cyc.size() - 1] - p, 326);

    finish_test();
  end

  initial begin
    #200000;
    n_assert++; n_fail++;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    finish_test();
  end

endmodule
